// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory fetch bus and decode-side valid/ready stream of the fetch queue unit.
// master = fetch unit side, slave = memory/decode side.
interface fetch_queue_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
);
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Sequential fetch into a 1-cycle synchronous instruction memory, buffering {instr, pc}
// in a DEPTH-entry FIFO toward decode, with run/halt control and branch redirect/flush.
module fetch_queue_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 9,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 f_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_addr,
  input  logic                 halt,
  input  logic                 taken,
  input  logic [PC_W-1:0]      target,
  output logic                 busy,
  fetch_queue_unit_if.master   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    fpc, fpc_nxt;
  logic               inflight;
  logic [PC_W-1:0]    tag_pc;

  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [PC_W-1:0]    q_pc    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;

  logic run, redirect, flush, issue, push, pop, not_empty, head_valid;

  assign run       = (state == RUN);
  assign redirect  = run & (taken | start);
  // A start from IDLE also drops any return still in flight from before the halt.
  assign flush     = start | redirect;
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = run & ~redirect & (occupancy < (CNT_W + 1)'(DEPTH));
  assign push      = inflight & ~flush;
  assign not_empty = (count != '0);
  assign head_valid = not_empty & ~redirect;
  assign pop       = head_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (taken || start) state_nxt = RUN;
        else if (halt)      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fpc_nxt = fpc;
    if (run && taken)  fpc_nxt = target;
    else if (start)    fpc_nxt = start_addr;
    else if (issue)    fpc_nxt = fpc + 1'b1;
  end

  always_ff @(posedge f_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      inflight <= 1'b0;
      tag_pc   <= '0;
    end else begin
      state    <= state_nxt;
      fpc      <= fpc_nxt;
      inflight <= issue;
      if (issue) tag_pc <= fpc;
    end
  end

  always_ff @(posedge f_clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head outputs are masked to zero whenever the queue is empty.
  always_ff @(posedge f_clk) begin
    if (push && !flush) begin
      q_instr[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]    <= tag_pc;
    end
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fpc;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = not_empty ? q_instr[rd_ptr] : '0;
  assign bus.out_pc    = not_empty ? q_pc[rd_ptr]    : '0;
  assign busy          = run;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: vector table, directed corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_fetch_queue_unit;
  localparam int              PC_W     = 8;
  localparam int              INSTR_W  = 9;
  localparam int              DEPTH    = 4;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  logic              f_clk = 1'b0;
  logic              reset;
  logic              start, halt, taken, busy;
  logic [PC_W-1:0]   start_addr, target;

  fetch_queue_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_queue_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .f_clk(f_clk), .reset(reset), .start(start), .start_addr(start_addr),
    .halt(halt), .taken(taken), .target(target), .busy(busy), .bus(bus.master)
  );

  always #5 f_clk = ~f_clk;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return {^pc, pc ^ 8'hA5};
  endfunction

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge f_clk)
    if (bus.imem_en === 1'b1) bus.imem_rdata <= instr_of(bus.imem_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run flag, fetch PC, one in-flight slot and a queue of {pc, instr}.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ins;
  } ent_t;

  bit              m_run;
  logic [PC_W-1:0] m_fpc;
  bit              m_infl;
  logic [PC_W-1:0] m_ifpc;
  ent_t            m_q[$];

  logic               o_en, o_valid, o_busy;
  logic [PC_W-1:0]    o_addr, o_pc;
  logic [INSTR_W-1:0] o_ins;

  task automatic model_reset();
    m_run  = 1'b0;
    m_fpc  = RESET_PC;
    m_infl = 1'b0;
    m_q.delete();
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance model at the rising edge.
  task automatic step(input bit st, input logic [PC_W-1:0] sa, input bit hl,
                      input bit tk, input logic [PC_W-1:0] tg, input bit rdy);
    bit   redir, e_en, e_valid, flush;
    ent_t e;
    start = st; start_addr = sa; halt = hl; taken = tk; target = tg; bus.out_ready = rdy;
    @(negedge f_clk);
    o_en = bus.imem_en; o_addr = bus.imem_addr; o_valid = bus.out_valid;
    o_pc = bus.out_pc;  o_ins  = bus.out_instr; o_busy  = busy;
    redir   = m_run && (tk || st);
    e_en    = m_run && !redir && ((m_q.size() + int'(m_infl)) < DEPTH);
    e_valid = (m_q.size() != 0) && !redir;
    check("imem_en", o_en, e_en);
    if (e_en) check("imem_addr", o_addr, m_fpc);
    check("out_valid", o_valid, e_valid);
    check("busy", o_busy, m_run);
    if (m_q.size() != 0) begin
      check("out_pc", o_pc, m_q[0].pc);
      check("out_instr", o_ins, m_q[0].ins);
    end else begin
      check("out_pc_empty", o_pc, 0);
      check("out_instr_empty", o_ins, 0);
    end
    @(posedge f_clk);
    flush = st || redir;
    if (e_valid && rdy) void'(m_q.pop_front());
    if (m_infl && !flush) begin
      e.pc  = m_ifpc;
      e.ins = instr_of(m_ifpc);
      m_q.push_back(e);
    end
    if (flush) m_q.delete();
    m_infl = e_en;
    if (e_en) m_ifpc = m_fpc;
    if (m_run && tk)  m_fpc = tg;
    else if (st)      m_fpc = sa;
    else if (e_en)    m_fpc = m_fpc + 8'd1;
    if (st)                        m_run = 1'b1;
    else if (m_run && !tk && hl)   m_run = 1'b0;
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    start = 0; halt = 0; taken = 0; bus.out_ready = 0;
    reset = 1'b1;
    model_reset();
    @(posedge f_clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit st; logic [7:0] sa; bit hl; bit tk; logic [7:0] tg; bit rdy;
    bit e_en; logic [7:0] e_addr; bit e_valid; logic [7:0] e_pc; bit e_busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] iss[$];
    logic [7:0] pops[$];
    int         n_iss, n_pop, first_iss;
    bit         seen23;
    bit         st, hl, tk, rdy;

    //          st sa     hl tk tg     rdy en addr   v  pc     busy
    tbl[0]  = '{1, 8'h10, 0, 0, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0};
    tbl[1]  = '{0, 8'h00, 0, 0, 8'h00, 1,  1, 8'h10, 0, 8'h00, 1};
    tbl[2]  = '{0, 8'h00, 0, 0, 8'h00, 1,  1, 8'h11, 0, 8'h00, 1};
    tbl[3]  = '{0, 8'h00, 0, 0, 8'h00, 1,  1, 8'h12, 1, 8'h10, 1};
    tbl[4]  = '{0, 8'h00, 0, 0, 8'h00, 1,  1, 8'h13, 1, 8'h11, 1};
    tbl[5]  = '{0, 8'h00, 0, 1, 8'h40, 1,  0, 8'h00, 0, 8'h00, 1};
    tbl[6]  = '{0, 8'h00, 0, 0, 8'h00, 1,  1, 8'h40, 0, 8'h00, 1};
    tbl[7]  = '{0, 8'h00, 0, 0, 8'h00, 1,  1, 8'h41, 0, 8'h00, 1};
    tbl[8]  = '{0, 8'h00, 0, 0, 8'h00, 1,  1, 8'h42, 1, 8'h40, 1};
    tbl[9]  = '{0, 8'h00, 1, 0, 8'h00, 1,  1, 8'h43, 1, 8'h41, 1};
    tbl[10] = '{0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 1, 8'h42, 0};
    tbl[11] = '{0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 1, 8'h43, 0};
    tbl[12] = '{0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0};

    reset = 1'b1; start = 0; halt = 0; taken = 0; start_addr = '0; target = '0;
    bus.out_ready = 1'b0; bus.imem_rdata = '0;
    model_reset();
    repeat (2) @(posedge f_clk);
    #1;
    check("rst_imem_en", bus.imem_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_instr", bus.out_instr, 0);
    reset = 1'b0;

    // Vector table: start, streaming, branch redirect, halt and drain.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].st, tbl[i].sa, tbl[i].hl, tbl[i].tk, tbl[i].tg, tbl[i].rdy);
      check("tbl_en", o_en, tbl[i].e_en);
      if (tbl[i].e_en) check("tbl_addr", o_addr, tbl[i].e_addr);
      check("tbl_valid", o_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        check("tbl_pc", o_pc, tbl[i].e_pc);
        check("tbl_instr", o_ins, instr_of(tbl[i].e_pc));
      end
      check("tbl_busy", o_busy, tbl[i].e_busy);
    end

    // PC wrap-around.
    do_reset();
    step(1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b1);
    iss.delete(); pops.delete();
    for (int i = 0; i < 7; i++) begin
      idle(1'b1);
      if (o_en)    iss.push_back(o_addr);
      if (o_valid) pops.push_back(o_pc);
    end
    check("wrap_iss_n", iss.size() >= 4, 1);
    check("wrap_pop_n", pops.size() >= 4, 1);
    if (iss.size() >= 4 && pops.size() >= 4) begin
      check("wrap_iss0", iss[0], 8'hFE); check("wrap_iss1", iss[1], 8'hFF);
      check("wrap_iss2", iss[2], 8'h00); check("wrap_iss3", iss[3], 8'h01);
      check("wrap_pop0", pops[0], 8'hFE); check("wrap_pop1", pops[1], 8'hFF);
      check("wrap_pop2", pops[2], 8'h00); check("wrap_pop3", pops[3], 8'h01);
    end

    // Back-pressure: exactly DEPTH fetches with no consumer, then resume at 0x14.
    do_reset();
    step(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
    iss.delete(); pops.delete();
    for (int i = 0; i < 8; i++) begin
      idle(1'b0);
      if (o_en) iss.push_back(o_addr);
    end
    check("bp_issue_count", iss.size(), DEPTH);
    check("bp_stalled_en", o_en, 0);
    if (iss.size() == DEPTH) check("bp_last_issue", iss[DEPTH-1], 8'h13);
    first_iss = -1;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (o_valid) pops.push_back(o_pc);
      if (o_en && first_iss < 0) first_iss = int'(o_addr);
    end
    check("bp_pop_n", pops.size() >= 4, 1);
    if (pops.size() >= 4)
      for (int i = 0; i < 4; i++) check("bp_pop_order", pops[i], 8'h10 + 8'(i));
    check("bp_resume_addr", first_iss, 32'h14);

    // Branch with three queued entries and one return in flight.
    do_reset();
    step(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (4) idle(1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 1'b1);
    check("br_valid_cut", o_valid, 0);
    check("br_en_cut", o_en, 0);
    idle(1'b1);
    check("br_new_en", o_en, 1);
    check("br_new_addr", o_addr, 8'h40);
    check("br_queue_empty", o_valid, 0);
    pops.delete();
    seen23 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      if (o_valid) begin
        pops.push_back(o_pc);
        if (o_pc == 8'h23) seen23 = 1'b1;
      end
    end
    check("br_squashed_23", seen23, 0);
    check("br_first_pop", (pops.size() != 0) ? pops[0] : 8'hFF, 8'h40);

    // Halt with entries queued, drain, then restart at 0x80.
    idle(1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(1'b0);
    check("halt_en", o_en, 0);
    check("halt_busy", o_busy, 0);
    check("halt_kept", o_valid, 1);
    n_pop = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      if (o_valid) n_pop++;
    end
    check("halt_drained", n_pop >= 2, 1);
    check("halt_empty", o_valid, 0);
    step(1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1'b1);
    check("restart_en", o_en, 1);
    check("restart_addr", o_addr, 8'h80);

    // Asynchronous reset mid-stream with a full queue.
    do_reset();
    step(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (8) idle(1'b0);
    check("ar_full_valid", o_valid, 1);
    start = 0; halt = 0; taken = 0; bus.out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_en", bus.imem_en, 0);
    check("ar_busy", busy, 0);
    model_reset();
    @(posedge f_clk); #1;
    reset = 1'b0;
    check("ar_fpc", dut.fpc, RESET_PC);
    repeat (3) idle(1'b1);
    check("ar_no_push", o_valid, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom % 24) == 0;
      if (!m_run && ($urandom % 4) == 0) st = 1'b1;
      hl  = ($urandom % 12) == 0;
      tk  = ($urandom % 10) == 0;
      rdy = ($urandom % 4) != 0;
      step(st, 8'($urandom), hl, tk, 8'($urandom), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
